// File: rtl/imul_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package imul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int IMUL_REQ_NBITS  = 64;
    localparam int IMUL_RESP_NBITS = 32;

    // Width of a requester index (ptr, owner, grant_id).
    function automatic int ptr_nbits(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/imul_rr_arb.sv
// Combinational round-robin arbiter: lowest requester at or after ptr wins, wrapping to 0.
module imul_rr_arb
    import imul_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = ptr_nbits(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_id,
    output logic            any
);

    always_comb begin
        logic [PW:0]   idx_w;
        logic [PW-1:0] idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx_w    = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, ptr} + (PW+1)'(k);
            if (idx_w >= (PW+1)'(NREQ))
                idx_w = idx_w - (PW+1)'(NREQ);
            idx = idx_w[PW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/imul_rr_scheduler.sv
// Shares one iterative multiplier among NREQ val/rdy requesters, one transaction in flight.
module imul_rr_scheduler
    import imul_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_val,
    output logic [NREQ-1:0]             req_rdy,
    input  logic [NREQ*64-1:0]          req_msg,
    output logic [NREQ-1:0]             resp_val,
    input  logic [NREQ-1:0]             resp_rdy,
    output logic [NREQ*32-1:0]          resp_msg,
    output logic                        mul_istream_val,
    input  logic                        mul_istream_rdy,
    output logic [63:0]                 mul_istream_msg,
    input  logic                        mul_ostream_val,
    output logic                        mul_ostream_rdy,
    input  logic [31:0]                 mul_ostream_msg,
    output logic [15:0]                 done_count
);

    localparam int PW = ptr_nbits(NREQ);

    state_e                     state;
    logic [PW-1:0]              ptr;
    logic [PW-1:0]              owner;
    logic [IMUL_REQ_NBITS-1:0]  op;
    logic [IMUL_RESP_NBITS-1:0] result;

    logic [NREQ-1:0]            grant;
    logic [PW-1:0]              grant_id;
    logic                       any;
    logic [PW-1:0]              next_ptr;
    logic [NREQ-1:0]            owner_oh;
    logic [IMUL_REQ_NBITS-1:0]  req_lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign req_lane[i] = req_msg[i*IMUL_REQ_NBITS +: IMUL_REQ_NBITS];
    end

    imul_rr_arb #(.NREQ(NREQ)) u_arb (
        .req      (req_val),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    assign next_ptr = (grant_id == PW'(NREQ-1)) ? '0 : grant_id + PW'(1);
    assign owner_oh = NREQ'(1) << owner;

    // Handshake-facing outputs are pure decodes of the state register.
    assign req_rdy         = (state == IDLE) ? grant : '0;
    assign mul_istream_val = (state == ISSUE);
    assign mul_istream_msg = op;
    assign mul_ostream_rdy = (state == WAIT);
    assign resp_val        = (state == RESP) ? owner_oh : '0;
    assign resp_msg        = {NREQ{result}};

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            op         <= '0;
            result     <= '0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    op    <= req_lane[grant_id];
                    owner <= grant_id;
                    ptr   <= next_ptr;
                    state <= ISSUE;
                end
                ISSUE: if (mul_istream_rdy) state <= WAIT;
                WAIT: if (mul_ostream_val) begin
                    result <= mul_ostream_msg;
                    state  <= RESP;
                end
                RESP: if (resp_rdy[owner]) begin
                    done_count <= done_count + 16'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imul_rr_scheduler.sv
// Directed bench for imul_rr_scheduler; the bench plays every requester and the multiplier.
module tb_imul_rr_scheduler;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_val;
    logic [NREQ-1:0]      req_rdy;
    logic [NREQ*64-1:0]   req_msg;
    logic [NREQ-1:0]      resp_val;
    logic [NREQ-1:0]      resp_rdy;
    logic [NREQ*32-1:0]   resp_msg;
    logic                 mul_istream_val;
    logic                 mul_istream_rdy;
    logic [63:0]          mul_istream_msg;
    logic                 mul_ostream_val;
    logic                 mul_ostream_rdy;
    logic [31:0]          mul_ostream_msg;
    logic [15:0]          done_count;

    imul_rr_scheduler #(.NREQ(NREQ)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_msg         (req_msg),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_msg        (resp_msg),
        .mul_istream_val (mul_istream_val),
        .mul_istream_rdy (mul_istream_rdy),
        .mul_istream_msg (mul_istream_msg),
        .mul_ostream_val (mul_ostream_val),
        .mul_ostream_rdy (mul_ostream_rdy),
        .mul_ostream_msg (mul_ostream_msg),
        .done_count      (done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] prod;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] ops [NREQ];
    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          exp_done = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [NREQ-1:0] val);
        req_val = val;
        for (int i = 0; i < NREQ; i++) req_msg[i*64 +: 64] = ops[i];
    endtask

    function automatic logic [31:0] mul_model(input logic [63:0] m);
        logic [31:0] a, b;
        a = m[63:32];
        b = m[31:0];
        return a * b;
    endfunction

    function automatic string trace();
        logic [1:0] s;
        string      nm;
        s = dut.state;
        case (s)
            2'd0:    nm = "IDLE";
            2'd1:    nm = "ISSUE";
            2'd2:    nm = "WAIT";
            default: nm = "RESP";
        endcase
        return $sformatf("%-5s own=%0d req %b/%b iss %b/%b ost %b/%b resp %b/%b",
                         nm, dut.owner, req_val, req_rdy, mul_istream_val, mul_istream_rdy,
                         mul_ostream_val, mul_ostream_rdy, resp_val, resp_rdy);
    endfunction

    // One full transaction; entered with the DUT in IDLE and requests already settled.
    task automatic run_txn(input int port, input int iss_stall, input int resp_stall);
        exp_t            e;
        logic [63:0]     captured;
        logic [NREQ-1:0] oh;
        oh       = '0;
        oh[port] = 1'b1;
        check($sformatf("grant_p%0d", port), req_rdy, oh);
        e.port = port;
        e.prod = mul_model(ops[port]);
        sb.push_back(e);
        tick();
        mul_istream_rdy = 1'b0;
        for (int i = 0; i < iss_stall; i++) begin
            #1;
            check("issue_stall_val", mul_istream_val, 1);
            check("issue_stall_msg", mul_istream_msg, ops[port]);
            check("issue_stall_rdy", req_rdy, 0);
            tick();
        end
        mul_istream_rdy = 1'b1;
        #1;
        check("issue_val", mul_istream_val, 1);
        check("issue_msg", mul_istream_msg, ops[port]);
        captured = mul_istream_msg;
        tick();
        mul_istream_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("wait_ordy", mul_ostream_rdy, 1);
            tick();
        end
        mul_ostream_val = 1'b1;
        mul_ostream_msg = mul_model(captured);
        tick();
        mul_ostream_val = 1'b0;
        mul_ostream_msg = 32'hDEAD_BEEF;
        resp_rdy = '0;
        for (int i = 0; i < resp_stall; i++) begin
            #1;
            check("resp_hold_val", resp_val, oh);
            check("resp_hold_rdy", req_rdy, 0);
            tick();
        end
        resp_rdy = '1;
        #1;
        e = sb.pop_front();
        check($sformatf("resp_val_p%0d", e.port), resp_val, 64'(1) << e.port);
        check($sformatf("resp_msg_p%0d", e.port), resp_msg[e.port*32 +: 32], e.prod);
        tick();
        resp_rdy = '0;
        exp_done++;
        check("done_count", done_count, 16'(exp_done));
        $display("trace: %s", trace());
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_rdy"}, req_rdy, 0);
        check({tag, "_iss_val"}, mul_istream_val, 0);
        check({tag, "_ost_rdy"}, mul_ostream_rdy, 0);
        check({tag, "_resp_val"}, resp_val, 0);
        check({tag, "_done"}, done_count, 16'(exp_done));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t dropped;
        reset = 1'b1;
        req_val = '0;
        req_msg = '0;
        resp_rdy = '0;
        mul_istream_rdy = 1'b0;
        mul_ostream_val = 1'b0;
        mul_ostream_msg = '0;
        for (int i = 0; i < NREQ; i++) ops[i] = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_idle_outputs("reset");
        check("reset_resp_msg", resp_msg[31:0], 0);

        // Single request on port 0: 3 * 4.
        ops[0] = {32'd3, 32'd4};
        drive_req(4'b0001);
        #1;
        run_txn(0, 0, 0);
        drive_req(4'b0000);

        // Plain reset realigns the pointer to 0 and clears the count.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_done = 0;
        #1;
        check_idle_outputs("reset2");

        // All four valid continuously: grants 0,1,2,3,0 with backpressure on port 1.
        ops[0] = {32'd5, 32'd6};
        ops[1] = {32'd7, 32'd8};
        ops[2] = {32'hFFFF_FFFF, 32'd2};
        ops[3] = {32'h0001_0000, 32'h0001_0003};
        drive_req(4'b1111);
        #1;
        run_txn(0, 0, 0);
        #1;
        run_txn(1, 5, 7);
        #1;
        run_txn(2, 1, 0);
        #1;
        run_txn(3, 0, 2);
        ops[0] = {32'd100, 32'd200};
        drive_req(4'b1111);
        #1;
        run_txn(0, 0, 0);

        // Port 2 alone leaves ptr=3; then ports 1 and 3 must go 3 then 1.
        ops[2] = {32'd9, 32'd9};
        drive_req(4'b0100);
        #1;
        run_txn(2, 0, 0);
        ops[1] = {32'd11, 32'd13};
        ops[3] = {32'h8000_0000, 32'd3};
        drive_req(4'b1010);
        #1;
        run_txn(3, 0, 0);
        #1;
        run_txn(1, 0, 0);
        drive_req(4'b0000);

        // Reset while WAITing for the product aborts the transaction.
        ops[2] = {32'd21, 32'd2};
        drive_req(4'b0100);
        #1;
        check("abort_grant", req_rdy, 4'b0100);
        tick();
        mul_istream_rdy = 1'b1;
        tick();
        mul_istream_rdy = 1'b0;
        drive_req(4'b0000);
        #1;
        check("abort_in_wait", mul_ostream_rdy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_done = 0;
        #1;
        check_idle_outputs("abort");
        ops[0] = {32'd6, 32'd7};
        ops[3] = {32'd2, 32'd2};
        drive_req(4'b1001);
        #1;
        run_txn(0, 0, 0);
        drive_req(4'b0000);

        // A stray product while IDLE must be ignored.
        mul_ostream_val = 1'b1;
        mul_ostream_msg = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("spurious_ost_rdy", mul_ostream_rdy, 0);
            check("spurious_resp", resp_val, 0);
            check("spurious_done", done_count, 16'(exp_done));
            tick();
        end
        mul_ostream_val = 1'b0;
        ops[1] = {32'd1000, 32'd1000};
        drive_req(4'b0010);
        #1;
        run_txn(1, 0, 0);
        drive_req(4'b0000);

        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
